// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulation unit.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PSUM_BW_DEF   = 16;
    localparam int ACC_GUARD_DEF = 4;
    localparam int ACC_W_DEF     = PSUM_BW_DEF + ACC_GUARD_DEF;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One lane: sign-extend and overwrite-or-add into the accumulator, plus output post-processing.
// PSUM_ACC_RELU_EN: clamp negative results to zero before saturation.
module psum_acc_lane #(
    parameter int PSUM_BW = 16,
    parameter int ACC_W   = 20
) (
    input  logic [PSUM_BW-1:0] psum,
    input  logic [ACC_W-1:0]   acc_old,
    input  logic               first,
    output logic [ACC_W-1:0]   acc_new,
    input  logic [ACC_W-1:0]   acc_rd,
    output logic [PSUM_BW-1:0] res
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};
    localparam logic [PSUM_BW-1:0] RES_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] RES_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    logic [ACC_W-1:0]        ext;
    logic signed [ACC_W-1:0] acc_s;

    assign ext     = {{(ACC_W-PSUM_BW){psum[PSUM_BW-1]}}, psum};
    assign acc_new = first ? ext : acc_old + ext;
    assign acc_s   = acc_rd;

    always_comb begin
        res = acc_rd[PSUM_BW-1:0];
`ifdef PSUM_ACC_RELU_EN
        if (acc_rd[ACC_W-1])
            res = '0;
        else if (acc_s > SAT_MAX)
            res = RES_MAX;
`else
        if (acc_s > SAT_MAX)
            res = RES_MAX;
        else if (acc_s < SAT_MIN)
            res = RES_MIN;
`endif
    end

endmodule

// File: rtl/psum_acc_unit.sv
// Pops OFIFO rows, accumulates per-pixel partial sums over kij passes, then drains processed rows.
// PSUM_ACC_RELU_EN selects ReLU-then-saturate instead of plain signed saturation.
//
//   state | meaning
//   IDLE  | waiting for start, config latched on start
//   ACC   | popping OFIFO, one beat per valid row
//   DRAIN | streaming buffer rows out over valid/ready
//   DONE  | one-cycle completion pulse
module psum_acc_unit
    import psum_acc_pkg::*;
#(
    parameter int COL       = 8,
    parameter int PSUM_BW   = PSUM_BW_DEF,
    parameter int ACC_GUARD = ACC_GUARD_DEF,
    parameter int NUM_PIX   = 16,
    parameter int KIJ_MAX   = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [$clog2(KIJ_MAX+1)-1:0]   cfg_num_kij,
    input  logic [$clog2(NUM_PIX+1)-1:0]   cfg_num_pix,
    input  logic [COL*PSUM_BW-1:0]         i_data,
    input  logic                           i_valid,
    output logic                           o_rd,
    output logic [COL*PSUM_BW-1:0]         o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int ACC_W = PSUM_BW + ACC_GUARD;
    localparam int KW    = $clog2(KIJ_MAX+1);
    localparam int PNW   = $clog2(NUM_PIX+1);
    localparam int KCW   = cnt_w(KIJ_MAX);
    localparam int PCW   = cnt_w(NUM_PIX);
    localparam logic [KW-1:0]  KIJ_MAX_C = KW'(KIJ_MAX);
    localparam logic [PNW-1:0] PIX_MAX_C = PNW'(NUM_PIX);

    state_t state, state_nx;

    logic [KCW-1:0] kij_cnt, kij_last;
    logic [PCW-1:0] pix_cnt, pix_last, out_idx, rd_idx;
    logic [KW-1:0]  kij_cl;
    logic [PNW-1:0] pix_cl;
    logic           beat, last_beat, xfer, last_xfer;

    logic [COL*ACC_W-1:0]   acc_buf [NUM_PIX];
    logic [COL*ACC_W-1:0]   acc_row_old, acc_row_new, acc_row_rd;
    logic [COL*PSUM_BW-1:0] res_row;

    // Zero means one pass / one pixel; oversized values clamp to the buffer limits.
    always_comb begin
        kij_cl = cfg_num_kij;
        if (cfg_num_kij == '0)
            kij_cl = KW'(1);
        else if (cfg_num_kij > KIJ_MAX_C)
            kij_cl = KIJ_MAX_C;
        pix_cl = cfg_num_pix;
        if (cfg_num_pix == '0)
            pix_cl = PNW'(1);
        else if (cfg_num_pix > PIX_MAX_C)
            pix_cl = PIX_MAX_C;
    end

    assign beat      = (state == ACC) && i_valid;
    assign last_beat = beat && (kij_cnt == kij_last) && (pix_cnt == pix_last);
    assign xfer      = (state == DRAIN) && o_valid && i_ready;
    assign last_xfer = xfer && (out_idx == pix_last);

    // Drain entry reads row 0; afterwards prefetch the row following the one on the bus.
    assign rd_idx      = o_valid ? out_idx + 1'b1 : '0;
    assign acc_row_old = acc_buf[pix_cnt];
    assign acc_row_rd  = acc_buf[rd_idx];

    for (genvar k = 0; k < COL; k++) begin : g_lane
        psum_acc_lane #(
            .PSUM_BW (PSUM_BW),
            .ACC_W   (ACC_W)
        ) u_lane (
            .psum    (i_data[k*PSUM_BW +: PSUM_BW]),
            .acc_old (acc_row_old[k*ACC_W +: ACC_W]),
            .first   (kij_cnt == '0),
            .acc_new (acc_row_new[k*ACC_W +: ACC_W]),
            .acc_rd  (acc_row_rd[k*ACC_W +: ACC_W]),
            .res     (res_row[k*PSUM_BW +: PSUM_BW])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACC;
            ACC:     if (last_beat) state_nx = DRAIN;
            DRAIN:   if (last_xfer) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_rd   = 1'b0;
        o_busy = 1'b1;
        o_done = 1'b0;
        case (state)
            IDLE:    o_busy = 1'b0;
            ACC:     o_rd = i_valid;
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kij_cnt  <= '0;
            pix_cnt  <= '0;
            kij_last <= '0;
            pix_last <= '0;
            out_idx  <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    kij_last <= KCW'(kij_cl - 1'b1);
                    pix_last <= PCW'(pix_cl - 1'b1);
                    kij_cnt  <= '0;
                    pix_cnt  <= '0;
                end
                ACC: if (beat) begin
                    if (pix_cnt == pix_last) begin
                        pix_cnt <= '0;
                        kij_cnt <= kij_cnt + 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!o_valid) begin
                        o_data  <= res_row;
                        o_valid <= 1'b1;
                        out_idx <= '0;
                    end else if (i_ready) begin
                        if (out_idx == pix_last) begin
                            o_valid <= 1'b0;
                        end else begin
                            o_data  <= res_row;
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer is deliberately not reset: pass 0 of every tile overwrites each used entry.
    always_ff @(posedge clk) begin
        if (beat)
            acc_buf[pix_cnt] <= acc_row_new;
    end

endmodule

// File: tb/tb_psum_acc_unit.sv
// Randomized bench for psum_acc_unit against an arithmetic sum-then-clip reference model.
module tb_psum_acc_unit;

    localparam int COL       = 8;
    localparam int PSUM_BW   = 16;
    localparam int ACC_GUARD = 4;
    localparam int NUM_PIX   = 16;
    localparam int KIJ_MAX   = 9;
    localparam int ACC_W     = PSUM_BW + ACC_GUARD;
    localparam int KW        = $clog2(KIJ_MAX+1);
    localparam int PNW       = $clog2(NUM_PIX+1);
    localparam int DW        = COL*PSUM_BW;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [KW-1:0]  cfg_num_kij = '0;
    logic [PNW-1:0] cfg_num_pix = '0;
    logic [DW-1:0]  i_data = '0;
    logic           i_valid = 1'b0;
    logic           i_ready = 1'b0;
    logic           o_rd, o_valid, o_busy, o_done;
    logic [DW-1:0]  o_data;

    psum_acc_unit #(
        .COL(COL), .PSUM_BW(PSUM_BW), .ACC_GUARD(ACC_GUARD),
        .NUM_PIX(NUM_PIX), .KIJ_MAX(KIJ_MAX)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_num_kij(cfg_num_kij), .cfg_num_pix(cfg_num_pix),
        .i_data(i_data), .i_valid(i_valid), .o_rd(o_rd),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Beat b of a tile is pass b/num_pix, pixel b%num_pix.
    logic [PSUM_BW-1:0] din [KIJ_MAX*NUM_PIX][COL];

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int eff_cfg(input int v, input int mx);
        if (v == 0) return 1;
        if (v > mx) return mx;
        return v;
    endfunction

    // Sum wraps at accumulator width, then the output clip is applied.
    function automatic logic [PSUM_BW-1:0] post(input int s);
        logic signed [ACC_W-1:0] w;
        int v;
        w = s[ACC_W-1:0];
        v = int'(w);
`ifdef PSUM_ACC_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[PSUM_BW-1:0];
    endfunction

    function automatic logic [DW-1:0] exp_row(input int p, input int nk, input int np);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < COL; l++) begin
            int s;
            s = 0;
            for (int k = 0; k < nk; k++)
                s += int'($signed(din[k*np+p][l]));
            r[l*PSUM_BW +: PSUM_BW] = post(s);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] pack_beat(input int b);
        logic [DW-1:0] r;
        for (int l = 0; l < COL; l++)
            r[l*PSUM_BW +: PSUM_BW] = din[b][l];
        return r;
    endfunction

    task automatic fill_const(input logic [PSUM_BW-1:0] v);
        for (int b = 0; b < KIJ_MAX*NUM_PIX; b++)
            for (int l = 0; l < COL; l++)
                din[b][l] = v;
    endtask

    task automatic fill_rand();
        for (int b = 0; b < KIJ_MAX*NUM_PIX; b++)
            for (int l = 0; l < COL; l++)
                din[b][l] = PSUM_BW'($urandom);
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_busy"}, DW'(o_busy), '0);
        check_val({tag, "_valid"}, DW'(o_valid), '0);
        check_val({tag, "_rd"}, DW'(o_rd), '0);
        check_val({tag, "_done"}, DW'(o_done), '0);
        check_val({tag, "_data"}, o_data, '0);
    endtask

    // stall_mode: 0 none, 1 three-cycle stall before row 1, 2 random
    task automatic run_tile(input int kcfg, input int pcfg, input bit bubbles, input int stall_mode,
                            input bit start_in_drain, input bit check_lat, input int abort_after);
        int nk, np, total, beats, budget, c0, cd, rows, stall_left, extra, dcnt;
        bit was_stalled, seen;
        logic [DW-1:0] held;
        nk = eff_cfg(kcfg, KIJ_MAX);
        np = eff_cfg(pcfg, NUM_PIX);
        total = nk*np;
        @(negedge clk);
        cfg_num_kij = KW'(kcfg);
        cfg_num_pix = PNW'(pcfg);
        start = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        beats = 0; budget = 0; c0 = -1; extra = 0; dcnt = 0;
        while (beats < total && budget < 2000) begin
            @(negedge clk);
            start = 1'b0;
            i_valid = bubbles ? (budget % 2 == 1) : 1'b1;
            i_data = pack_beat(beats);
            #1;
            if (budget == 0) check_val("busy_in_acc", DW'(o_busy), DW'(1));
            if (o_rd !== i_valid) check_val("rd_follows_valid", DW'(o_rd), DW'(i_valid));
            if (o_rd) begin
                if (c0 < 0) c0 = cyc;
                beats++;
                if (abort_after != 0 && beats == abort_after) begin
                    @(negedge clk);
                    i_valid = 1'b0;
                    reset = 1'b0;
                    #1;
                    check_idle_zero("reset_mid_acc");
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
            end
            budget++;
        end
        check_val("beats_consumed", DW'(beats), DW'(total));
        i_valid = 1'b1;
        rows = 0; budget = 0; was_stalled = 1'b0; held = '0;
        stall_left = (stall_mode == 1) ? 3 : 0;
        while (rows < np && budget < 2000) begin
            @(negedge clk);
            i_data = DW'({$urandom, $urandom, $urandom, $urandom});
            start = start_in_drain ? (budget % 3 == 0) : 1'b0;
            if (stall_mode == 1)
                i_ready = !(rows == 1 && stall_left > 0);
            else if (stall_mode == 2)
                i_ready = ($urandom % 3 != 0);
            else
                i_ready = 1'b1;
            if (!i_ready && stall_left > 0) stall_left--;
            #1;
            if (o_rd) extra++;
            if (o_done) dcnt++;
            if (was_stalled) begin
                check_val("hold_data", o_data, held);
                check_val("hold_valid", DW'(o_valid), DW'(1));
            end
            was_stalled = o_valid && !i_ready;
            held = o_data;
            if (o_valid && i_ready) begin
                check_val($sformatf("row%0d", rows), o_data, exp_row(rows, nk, np));
                rows++;
            end
            budget++;
        end
        check_val("rows_drained", DW'(rows), DW'(np));
        seen = 1'b0; cd = 0; budget = 0;
        while (!seen && budget < 20) begin
            @(negedge clk);
            start = 1'b0;
            i_ready = 1'b1;
            #1;
            if (o_rd) extra++;
            if (o_done) begin
                seen = 1'b1;
                dcnt++;
                cd = cyc;
            end
            budget++;
        end
        check_val("done_seen", DW'(seen), DW'(1));
        if (check_lat) check_val("latency", DW'(cd - c0 + 1), DW'(total + np + 2));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (o_rd) extra++;
            if (o_done) dcnt++;
        end
        i_valid = 1'b0;
        check_val("done_pulses", DW'(dcnt), DW'(1));
        check_val("extra_pops", DW'(extra), '0);
        check_val("idle_after", DW'(o_busy), '0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        fill_const(PSUM_BW'(5));
        run_tile(3, 2, 1'b0, 0, 1'b0, 1'b1, 0);

        fill_rand();
        for (int b = 0; b < KIJ_MAX*NUM_PIX; b++) begin
            din[b][0] = PSUM_BW'(-7);
            din[b][1] = PSUM_BW'(4);
        end
        run_tile(3, 2, 1'b0, 0, 1'b0, 1'b1, 0);

        fill_const(16'h7000);
        run_tile(9, 1, 1'b0, 0, 1'b0, 1'b1, 0);
        fill_const(16'h9000);
        run_tile(9, 2, 1'b0, 0, 1'b0, 1'b1, 0);

        fill_const(PSUM_BW'(5));
        run_tile(3, 2, 1'b1, 1, 1'b0, 1'b0, 0);

        fill_rand();
        run_tile(3, 4, 1'b0, 0, 1'b0, 1'b0, 4);
        fill_rand();
        run_tile(2, 3, 1'b0, 0, 1'b0, 1'b1, 0);

        fill_rand();
        run_tile(0, NUM_PIX, 1'b0, 0, 1'b1, 1'b1, 0);
        fill_rand();
        run_tile(15, 0, 1'b0, 0, 1'b0, 1'b1, 0);

        for (int t = 0; t < 6; t++) begin
            fill_rand();
            run_tile($urandom_range(0, KIJ_MAX), $urandom_range(0, NUM_PIX),
                     1'($urandom % 2), 2, 1'($urandom % 2), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_acc_unit.md
Name: psum_acc_unit

Overview:
- Parametrised successor to the fixed 3-deep SFP flush counter.
- Sits between OFIFO and output memory; pops OFIFO rows itself and accumulates COL-lane partial sums per output pixel across a runtime-configured number of kij passes.
- Holds a NUM_PIX-entry accumulation buffer, then drains post-processed results over a valid/ready handshake.

Parameters:
- COL, 8, number of lanes.
- PSUM_BW, 16, signed width of each input and output lane.
- ACC_GUARD, 4, extra internal accumulator bits per lane; accumulator width is PSUM_BW+ACC_GUARD.
- NUM_PIX, 16, accumulation buffer depth (maximum output pixels per tile).
- KIJ_MAX, 9, maximum kij passes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a tile; sampled only in IDLE.
- cfg_num_kij  in  $clog2(KIJ_MAX+1)  kij passes this tile.
- cfg_num_pix  in  $clog2(NUM_PIX+1)  pixels per pass.
- i_data  in  COL*PSUM_BW  OFIFO output row; lane k at [k*PSUM_BW +: PSUM_BW].
- i_valid  in  1  OFIFO non-empty.
- o_rd  out  1  OFIFO pop.
- o_data  out  COL*PSUM_BW  processed result row.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.
- o_busy  out  1  state is not IDLE.
- o_done  out  1  one-cycle pulse at tile completion.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; o_rd, o_valid, o_done, o_busy = 0; o_data = 0; all counters = 0. Buffer contents are not cleared; pass 0 overwrites them.
- FSM has four states: IDLE, ACC, DRAIN, DONE.
- IDLE:
  - On start=1, latch cfg_num_kij and cfg_num_pix and go to ACC.
  - A config value of 0 is treated as 1; values above the maximum clamp to KIJ_MAX / NUM_PIX.
- ACC:
  - o_rd = i_valid (combinational, ACC only). Each pop is one beat.
  - Beat at (kij_cnt, pix_cnt):
    - if kij_cnt==0, buf[pix_cnt] = sign-extended i_data;
    - else buf[pix_cnt] += sign-extended i_data, lane-wise, at accumulator width, wrapping silently.
  - pix_cnt increments per beat. When pix_cnt == num_pix-1 it wraps to 0 and kij_cnt increments.
  - On the beat with kij_cnt==num_kij-1 and pix_cnt==num_pix-1, go to DRAIN next cycle.
  - No pop while i_valid=0; counters hold.
- DRAIN:
  - Entry cycle loads the output register from buf[0]; o_valid rises one cycle after the DRAIN transition.
  - On o_valid && i_ready, load buf[idx+1] in the same edge, so back-to-back transfers occur at 1/cycle.
  - After the handshake of index num_pix-1, drop o_valid and go to DONE.
  - o_data and o_valid stay stable while i_ready=0.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Output lane processing (per lane): ReLU to 0 if negative, then saturate to 2^(PSUM_BW-1)-1.
- start outside IDLE is ignored. i_valid outside ACC is ignored, and OFIFO is not popped.
- Tile latency with i_valid and i_ready constantly high: num_kij*num_pix ACC cycles + 1 load cycle + num_pix DRAIN cycles + 1 DONE cycle.

Optional Feature:
- Macro: PSUM_ACC_RELU_EN.
- Defined: ReLU is applied before saturation, as above.
- Undefined: no ReLU; signed saturation to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].

Decomposition:
- Package psum_acc_pkg holds:
  - the FSM state enum (IDLE, ACC, DRAIN, DONE);
  - the localparam for accumulator width;
  - a helper function for counter widths.
- Sub-module psum_acc_lane, instantiated COL times. It performs one lane's sign-extend, overwrite-or-add, and output ReLU/saturation, and is combinational around the shared buffer.
- FSM, counters and buffer stay in psum_acc_unit.

Test Plan:
- Basic tile: kij=3, pix=2; all lanes receive +5 each beat with i_ready=1 -> two result rows, all lanes 15; o_done pulses once; total 10 cycles from the first ACC beat to o_done.
- Negative/ReLU: lane 0 accumulates -7 over 3 passes, lane 1 accumulates +4 -> with macro, lane 0 = 0 and lane 1 = 12; without macro, lane 0 = -21 and lane 1 = 12.
- Saturation: kij=9; each beat 16'sh7000 -> output 16'sh7FFF (without macro, 9 × -28672 -> 16'sh8000).
- Backpressure/bubbles: i_valid toggles every cycle and i_ready low for 3 cycles mid-drain -> results identical to the basic tile; o_data held stable while stalled; no extra pops.
- Reset mid-ACC: assert reset after 4 beats -> immediately IDLE with all outputs 0; a fresh tile then gives correct sums, with no residue from the previous buffer contents.
- Config edges: cfg_num_kij=0 and cfg_num_pix=NUM_PIX -> treated as a single pass; 16 rows equal to the inputs; start pulses during DRAIN ignored.
